alu_sequencer: RTL and testbench

Multi-cycle controller in front of the combinational 32-bit ALU (add / subtract / multiply / divide, 64-bit hi:lo result). It accepts one operation at a time over a valid/ready handshake and latches the operands. It drives the ALU select and operand buses for a per-operation settle time, then captures the 64-bit result into Z_HI/Z_LO registers and pulses `done`. It sits between the CPU control unit and the ALU, so deep multiply and divide paths are multi-cycle paths rather than single-cycle ones.

---
 rtl/alu_ctrl_pkg.sv | 23 ++
 rtl/alu_op_decode.sv | 39 +++
 rtl/alu_sequencer.sv | 109 ++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sequencer: request opcodes, ALU select codes
// and controller state encoding.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [3:0] SEL_ADD = 4'd3;
  localparam logic [3:0] SEL_SUB = 4'd2;
  localparam logic [3:0] SEL_MUL = 4'd1;
  localparam logic [3:0] SEL_DIV = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU select code and EXEC counter preload (LAT-1).
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 3
) (
  // The select follows the latched op, the preload follows the incoming op.
  input  op_e              sel_op,
  input  op_e              lat_op,
  output logic [3:0]       sel,
  output logic [CNT_W-1:0] lat_m1
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    sel = SEL_ADD;
    unique case (sel_op)
      OP_ADD: sel = SEL_ADD;
      OP_SUB: sel = SEL_SUB;
      OP_MUL: sel = SEL_MUL;
      OP_DIV: sel = SEL_DIV;
      default: sel = SEL_ADD;
    endcase
  end

  always_comb begin
    lat_m1 = CNT_W'(ADD_LAT - 1);
    unique case (lat_op)
      OP_ADD, OP_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
      OP_MUL:         lat_m1 = CNT_W'(MUL_LAT - 1);
      OP_DIV:         lat_m1 = CNT_W'(DIV_LAT - 1);
      default:        lat_m1 = CNT_W'(ADD_LAT - 1);
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for a combinational 32-bit ALU: latches operands,
// waits a per-op settle time, captures the 64-bit result and pulses done.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_c_hi,
  input  logic [31:0] alu_c_lo,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        done,
  output logic        dz_err,
  output logic        busy
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT)
                         ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                         : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

  state_e           state;
  op_e              op_q;
  op_e              req_op_e;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] req_lat_m1;
  logic             accept;
  logic             div_by_zero;

  assign req_op_e    = op_e'(req_op);
  assign req_ready   = (state != ST_EXEC);
  assign busy        = (state == ST_EXEC);
  assign accept      = req_valid & req_ready;
  assign div_by_zero = (req_op_e == OP_DIV) && (req_b == 32'd0);

  alu_op_decode #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_decode (
    .sel_op(op_q),
    .lat_op(req_op_e),
    .sel   (alu_sel),
    .lat_m1(req_lat_m1)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      alu_a  <= '0;
      alu_b  <= '0;
      cnt    <= '0;
      z_hi   <= '0;
      z_lo   <= '0;
      done   <= 1'b0;
      dz_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            op_q  <= req_op_e;
            alu_a <= req_a;
            alu_b <= req_b;
            cnt   <= req_lat_m1;
            // A zero divisor never reaches the ALU; results stay untouched.
            if (div_by_zero) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              dz_err <= 1'b1;
            end else begin
              state  <= ST_EXEC;
              dz_err <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            z_hi   <= alu_c_hi;
            z_lo   <= alu_c_lo;
            dz_err <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, back-to-back,
// reset-abort and randomized ops against a behavioural reference model.
module tb_alu_sequencer;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a, alu_b, alu_c_hi, alu_c_lo, z_hi, z_lo;
  logic [3:0]  alu_sel;
  logic        done, dz_err, busy;
  logic [63:0] alu_r;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  alu_sequencer #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_c_hi (alu_c_hi),
    .alu_c_lo (alu_c_lo),
    .z_hi     (z_hi),
    .z_lo     (z_lo),
    .done     (done),
    .dz_err   (dz_err),
    .busy     (busy)
  );

  // Combinational ALU attached to the sequencer; borrow/carry lands in hi[0].
  always_comb begin
    alu_r = '0;
    case (alu_sel)
      4'd3: alu_r = {32'd0, alu_a} + {32'd0, alu_b};
      4'd2: alu_r = {31'd0, (alu_a < alu_b), alu_a - alu_b};
      4'd1: alu_r = {32'd0, alu_a} * {32'd0, alu_b};
      4'd0: if (alu_b != 32'd0) alu_r = {alu_a % alu_b, alu_a / alu_b};
      default: alu_r = '0;
    endcase
  end
  assign alu_c_hi = alu_r[63:32];
  assign alu_c_lo = alu_r[31:0];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: result, divide-by-zero flag and cycle of done after the accept edge.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] prev, output logic [63:0] res,
                                 output logic dz, output int cyc);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    dz  = 1'b0;
    res = prev;
    cyc = ADD_LAT + 1;
    case (op)
      2'd0: res = ua + ub;
      2'd1: res = ((ua - ub) & 64'hFFFF_FFFF) | ((a < b) ? 64'h1_0000_0000 : 64'd0);
      2'd2: begin res = ua * ub; cyc = MUL_LAT + 1; end
      default: begin
        if (b == 32'd0) begin
          dz  = 1'b1;
          cyc = 1;
        end else begin
          res = ((ua % ub) << 32) | (ua / ub);
          cyc = DIV_LAT + 1;
        end
      end
    endcase
  endfunction

  logic [3:0] sel_tab [4] = '{4'd3, 4'd2, 4'd1, 4'd0};

  // Starts and ends at a negedge with the controller idle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_z, input logic exp_dz,
                        input int exp_cyc, input logic [63:0] prev_z);
    int  k;
    bit  seen;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check({name, " ready"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    k    = 1;
    seen = 0;
    while (!seen && k <= 40) begin
      if (done) begin
        seen = 1;
      end else begin
        check({name, " busy"}, 64'(busy), 64'd1);
        check({name, " ready low"}, 64'(req_ready), 64'd0);
        check({name, " sel"}, 64'(alu_sel), 64'(sel_tab[op]));
        check({name, " z held"}, {z_hi, z_lo}, prev_z);
        @(negedge clock);
        k++;
      end
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(k), 64'(exp_cyc));
    check({name, " z"}, {z_hi, z_lo}, exp_z);
    check({name, " dz_err"}, 64'(dz_err), 64'(exp_dz));
    @(negedge clock);
    check({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_z;
    logic        exp_dz;
    int          exp_cyc;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] zm;
  logic [63:0] rz;
  logic        rdz;
  int          rcyc;
  int          done_cnt;

  initial begin
    vecs[0] = '{op: 2'd0, a: 32'd5,          b: 32'd7,          exp_z: 64'd12,                  exp_dz: 1'b0, exp_cyc: 2};
    vecs[1] = '{op: 2'd1, a: 32'd3,          b: 32'd5,          exp_z: 64'h1_FFFF_FFFE,         exp_dz: 1'b0, exp_cyc: 2};
    vecs[2] = '{op: 2'd2, a: 32'h0001_0000,  b: 32'h0001_0000,  exp_z: 64'h1_0000_0000,         exp_dz: 1'b0, exp_cyc: 5};
    vecs[3] = '{op: 2'd0, a: 32'd5,          b: 32'd7,          exp_z: 64'd12,                  exp_dz: 1'b0, exp_cyc: 2};
    vecs[4] = '{op: 2'd3, a: 32'd100,        b: 32'd0,          exp_z: 64'd12,                  exp_dz: 1'b1, exp_cyc: 1};
    vecs[5] = '{op: 2'd3, a: 32'd100,        b: 32'd7,          exp_z: {32'd2, 32'd14},         exp_dz: 1'b0, exp_cyc: 9};

    // Reset values, sampled while reset is still asserted.
    #2;
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz", 64'(dz_err), 64'd0);
    check("rst sel", 64'(alu_sel), 64'd3);
    check("rst ops", {alu_a, alu_b}, 64'd0);
    check("rst z", {z_hi, z_lo}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    zm = '0;
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_z, vecs[i].exp_dz, vecs[i].exp_cyc, zm);
      zm = vecs[i].exp_z;
    end

    // Back-to-back: request held, second op accepted in the first op's DONE cycle.
    req_op = 2'd0; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
    @(negedge clock);
    check("b2b c1 ready", 64'(req_ready), 64'd0);
    req_a = 32'd2; req_b = 32'd2;
    @(negedge clock);
    check("b2b c2 done", 64'(done), 64'd1);
    check("b2b c2 z", {z_hi, z_lo}, 64'd2);
    check("b2b c2 ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b c3 done", 64'(done), 64'd0);
    check("b2b c3 busy", 64'(busy), 64'd1);
    @(negedge clock);
    check("b2b c4 done", 64'(done), 64'd1);
    check("b2b c4 z", {z_hi, z_lo}, 64'd4);
    @(negedge clock);
    zm = 64'd4;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (op == 2'd3 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 300));
      ref_op(op, a, b, zm, rz, rdz, rcyc);
      run_op($sformatf("rnd%0d", i), op, a, b, rz, rdz, rcyc, zm);
      zm = rz;
    end

    // Reset two cycles into a divide abandons it without a done.
    req_op = 2'd3; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("mid busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst ready", 64'(req_ready), 64'd1);
    check("mid rst sel", 64'(alu_sel), 64'd3);
    check("mid rst ops", {alu_a, alu_b}, 64'd0);
    check("mid rst z", {z_hi, z_lo}, 64'd0);
    check("mid rst flags", {62'd0, done, dz_err}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("mid no done", 64'(done_cnt), 64'd0);
    check("mid after ready", 64'(req_ready), 64'd1);
    check("mid after z", {z_hi, z_lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
